// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Arbitrates the single shared memory port of the multicycle core between
// the instruction-fetch path and the load/store data path, then sequences
// one memory access at a time through a request/done handshake.
// Each access has a bounded wait.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   if_req/if_addr               fetch request (held until if_gnt)
//   if_gnt/if_valid              fetch grant / completion pulses
//   d_req/d_we/d_addr/d_wdata/d_be  data request (held until d_gnt)
//   d_gnt/d_valid                data grant / completion pulses
//   rdata, err                   response data and timeout flag;
//                                qualified by if_valid/d_valid
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be  memory request bus
//   mem_rdata, mem_done          memory response, sampled only in ACCESS
//   busy                         high whenever the FSM is not IDLE
//
// Every output is a flop. The next-state logic computes the value that each
// output must carry in the following state.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_done,
    output logic                  busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e              state_q,      state_d;
    logic                owner_q,      owner_d;
    logic                last_owner_q, last_owner_d;
    logic [CNT_W-1:0]    count_q,      count_d;
    logic                mem_en_q,     mem_en_d;
    logic                mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q,     mem_be_d;
    logic                if_gnt_q,     if_gnt_d;
    logic                d_gnt_q,      d_gnt_d;
    logic                if_valid_q,   if_valid_d;
    logic                d_valid_q,    d_valid_d;
    logic [DATA_W-1:0]   rdata_q,      rdata_d;
    logic                err_q,        err_d;
    logic                busy_q,       busy_d;

    // When both requesters ask, the one that did not own the last access wins.
    logic sel_data_s;
    assign sel_data_s = d_req & (~if_req | (last_owner_q == OWN_FETCH));

    // Next-state and next-output computation for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        count_d      = count_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        if_valid_d   = 1'b0;
        d_valid_d    = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req | d_req) begin
                    state_d      = ST_ACCESS;
                    owner_d      = sel_data_s;
                    last_owner_d = sel_data_s;
                    count_d      = {CNT_W{1'b0}};
                    mem_en_d     = 1'b1;
                    busy_d       = 1'b1;
                    if (sel_data_s == OWN_DATA) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                        d_gnt_d     = 1'b1;
                    end else begin
                        // A fetch is always a full-word read.
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = {DATA_W{1'b0}};
                        mem_be_d    = {BE_W{1'b1}};
                        if_gnt_d    = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                // mem_done takes priority over a timeout in the same cycle.
                if (mem_done || (count_q == CNT_LAST)) begin
                    state_d  = ST_RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (mem_done) begin
                        rdata_d = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
                        err_d   = 1'b0;
                    end else begin
                        rdata_d = {DATA_W{1'b0}};
                        err_d   = 1'b1;
                    end
                    if (owner_q == OWN_DATA) begin
                        d_valid_d = 1'b1;
                    end else begin
                        if_valid_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any access immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FETCH;
            last_owner_q <= OWN_DATA;
            count_q      <= {CNT_W{1'b0}};
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            mem_be_q     <= {BE_W{1'b0}};
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            rdata_q      <= {DATA_W{1'b0}};
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            if_valid_q   <= if_valid_d;
            d_valid_q    <= d_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// Stimulus pushes one expected transaction per request into a queue.
// A negedge monitor does the rest: it checks the memory bus against the queue
// head while mem_en is high, and it checks grant placement. When a valid
// pulse appears, it pops the head and compares owner, rdata, err and the
// number of ACCESS cycles.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              reset_n;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_valid;
    logic [31:0]       rdata;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              busy;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .rdata    (rdata),
        .err      (err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata),
        .mem_done (mem_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          owner;   // 0 fetch, 1 data
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        bit          err;
        int          k;       // expected number of ACCESS cycles
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Memory model controls: done_after = 0 means never answer.
    int          done_after = 1;
    logic [31:0] mem_rd_v   = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic void expect_txn(bit owner, bit we, logic [31:0] addr, logic [31:0] wdata,
                                       logic [3:0] be, logic [31:0] rd, bit e, int k);
        exp_t x;
        x.owner = owner; x.we = we; x.addr = addr; x.wdata = wdata;
        x.be = be; x.rdata = rd; x.err = e; x.k = k;
        exp_q.push_back(x);
    endfunction

    // Memory responder: raises mem_done in the done_after-th ACCESS cycle.
    int acc_cnt = 0;
    initial begin
        mem_done  = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_en) acc_cnt++;
            else acc_cnt = 0;
            mem_done  = mem_en && (done_after != 0) && (acc_cnt == done_after);
            mem_rdata = mem_rd_v;
        end
    end

    // Monitor / scoreboard.
    int en_cnt   = 0;
    bit busy_chk = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                en_cnt   = 0;
                busy_chk = 0;
            end else begin
                if (busy_chk) begin
                    check("busy_after_resp", {63'd0, busy}, 64'd0);
                    busy_chk = 0;
                end
                if (mem_en) begin
                    en_cnt++;
                    if (exp_q.size() == 0) fail_evt("mem_en_unexpected");
                    else begin
                        check("mem_we",    {63'd0, mem_we},   {63'd0, exp_q[0].we});
                        check("mem_addr",  {32'd0, mem_addr}, {32'd0, exp_q[0].addr});
                        check("mem_wdata", {32'd0, mem_wdata},{32'd0, exp_q[0].wdata});
                        check("mem_be",    {60'd0, mem_be},   {60'd0, exp_q[0].be});
                    end
                end
                if (if_gnt || d_gnt) begin
                    if (exp_q.size() == 0) fail_evt("gnt_unexpected");
                    else begin
                        check("gnt_owner", {62'd0, if_gnt, d_gnt},
                              exp_q[0].owner ? 64'd1 : 64'd2);
                        check("gnt_first_cycle", 64'(en_cnt), 64'd1);
                    end
                end
                if (if_valid || d_valid) begin
                    check("gnt_valid_overlap", {62'd0, if_gnt, d_gnt}, 64'd0);
                    if (exp_q.size() == 0) fail_evt("valid_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("valid_owner", {62'd0, if_valid, d_valid}, e.owner ? 64'd1 : 64'd2);
                        check("rdata", {32'd0, rdata}, {32'd0, e.rdata});
                        check("err", {63'd0, err}, {63'd0, e.err});
                        check("access_cycles", 64'(en_cnt), 64'(e.k));
                        busy_chk = 1;
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    task automatic wait_gnt();
        bit got;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) got = 1;
        end
        if (!got) fail_evt("gnt_timeout");
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1;
        end
        if (!done) fail_evt("idle_timeout");
    endtask

    // Holds both requests until n grants are seen.
    task automatic wait_grants(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) seen++;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        if (seen < n) fail_evt("grant_count_timeout");
    endtask

    task automatic run_fetch(input logic [31:0] addr, input logic [31:0] mrd, input int dn,
                             input logic [31:0] exp_rd, input bit exp_err, input int k);
        mem_rd_v   = mrd;
        done_after = dn;
        expect_txn(1'b0, 1'b0, addr, 32'h0, 4'hF, exp_rd, exp_err, k);
        if_addr = addr;
        if_req  = 1'b1;
        wait_gnt();
        if_req = 1'b0;
        wait_idle();
    endtask

    task automatic run_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] mrd, input int dn,
                            input logic [31:0] exp_rd, input bit exp_err, input int k);
        mem_rd_v   = mrd;
        done_after = dn;
        expect_txn(1'b1, we, addr, wdata, be, exp_rd, exp_err, k);
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_be    = be;
        d_req   = 1'b1;
        wait_gnt();
        d_req = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_be    = 4'h0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("reset_ctrl", {56'd0, if_gnt, d_gnt, if_valid, d_valid, err, mem_en, mem_we, busy}, 64'd0);
        check("reset_rdata", {32'd0, rdata}, 64'd0);
        check("reset_mem_bus", {mem_addr, mem_wdata}, 64'd0);
        check("reset_mem_be", {60'd0, mem_be}, 64'd0);

        // Both requests held from reset: fetch, data, fetch, data.
        mem_rd_v   = 32'hA5A5_0001;
        done_after = 1;
        if_addr = 32'h200;
        d_addr  = 32'h300;
        d_we    = 1'b0;
        d_wdata = 32'h1111_2222;
        d_be    = 4'hF;
        expect_txn(1'b0, 1'b0, 32'h200, 32'h0,         4'hF, 32'hA5A5_0001, 1'b0, 1);
        expect_txn(1'b1, 1'b0, 32'h300, 32'h1111_2222, 4'hF, 32'hA5A5_0001, 1'b0, 1);
        expect_txn(1'b0, 1'b0, 32'h200, 32'h0,         4'hF, 32'hA5A5_0001, 1'b0, 1);
        expect_txn(1'b1, 1'b0, 32'h300, 32'h1111_2222, 4'hF, 32'hA5A5_0001, 1'b0, 1);
        if_req  = 1'b1;
        d_req   = 1'b1;
        reset_n = 1'b1;
        wait_grants(4);
        wait_idle();

        // Single fetch, done in the first ACCESS cycle.
        run_fetch(32'h100, 32'h0050_0093, 1, 32'h0050_0093, 1'b0, 1);

        // Store, done after 3 ACCESS cycles; rdata forced to zero.
        run_data(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 32'hFFFF_FFFF, 3, 32'h0, 1'b0, 3);

        // Load that never completes: timeout after TIMEOUT cycles.
        run_data(1'b0, 32'h80, 32'h0, 4'hF, 32'hCAFE_F00D, 0, 32'h0, 1'b1, TIMEOUT);

        // Following transaction completes normally.
        run_fetch(32'h104, 32'h0000_0013, 2, 32'h0000_0013, 1'b0, 2);

        // mem_done on the last allowed ACCESS cycle wins over the timeout.
        run_data(1'b0, 32'h84, 32'h0, 4'hF, 32'h1234_5678, TIMEOUT, 32'h1234_5678, 1'b0, TIMEOUT);

        // Reset during the 2nd ACCESS cycle of a load.
        mem_rd_v   = 32'h5555_AAAA;
        done_after = 0;
        expect_txn(1'b1, 1'b0, 32'h88, 32'h0, 4'hF, 32'h0, 1'b0, 2);
        d_we    = 1'b0;
        d_addr  = 32'h88;
        d_wdata = 32'h0;
        d_be    = 4'hF;
        d_req   = 1'b1;
        wait_gnt();
        d_req = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_mem_en", {63'd0, mem_en}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_gnt", {62'd0, if_gnt, d_gnt}, 64'd0);
        check("abort_valid", {62'd0, if_valid, d_valid}, 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);

        // After release, fetch wins the first conflict again.
        mem_rd_v   = 32'h0BAD_C0DE;
        done_after = 1;
        if_addr = 32'h400;
        d_addr  = 32'h500;
        d_wdata = 32'h0;
        expect_txn(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0BAD_C0DE, 1'b0, 1);
        expect_txn(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 32'h0BAD_C0DE, 1'b0, 1);
        if_req  = 1'b1;
        d_req   = 1'b1;
        reset_n = 1'b1;
        wait_grants(2);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
